// File: rtl/branch_unit_if.sv
// Branch unit request/result bundle.
//   master: producer side (drives the request, the result ready).
//   slave : branch_unit side (drives in_ready and the result payload).
// Request : in_valid, in_ready, in_type, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken
// Result  : out_valid, out_ready, out_taken, out_target, out_mispredict,
//           out_redirect, out_misaligned, out_illegal
interface branch_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_type;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect;
  logic            out_misaligned;
  logic            out_illegal;

  modport master (
    output in_valid, in_type, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_mispredict,
           out_redirect, out_misaligned, out_illegal
  );

  modport slave (
    input  in_valid, in_type, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_mispredict,
           out_redirect, out_misaligned, out_illegal
  );
endinterface

// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates one RV32I/RV64I conditional branch per
// transfer, computes the target and fall-through, compares against the
// front-end prediction and presents the result through a one-entry output
// register. Keeps saturating retired-branch and mispredict counters.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   flush        synchronous kill of the held result and of a same-cycle accept
//   cnt_clr      synchronous clear of both counters (wins over increment)
//   cnt_branches legal branches retired (saturating)
//   cnt_mispred  mispredicted branches retired (saturating)
//   bus          request/result bundle (slave side)
module branch_unit #(
  parameter int XLEN   = 32,
  parameter int CNT_W  = 16,
  parameter int ILEN_B = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_mispred,
  branch_unit_if.slave     bus
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready = !out_valid || out_ready, so a result leaving in the same cycle
  // frees the register for a new request (full throughput). The result
  // payload is held stable while out_valid && !out_ready.

  logic            valid_q,    valid_d;
  logic            taken_q,    taken_d;
  logic [XLEN-1:0] target_q,   target_d;
  logic            mispred_q,  mispred_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic            misal_q,    misal_d;
  logic            illegal_q,  illegal_d;
  logic [CNT_W-1:0] cnt_br_q,  cnt_br_d;
  logic [CNT_W-1:0] cnt_mp_q,  cnt_mp_d;

  logic            accept;
  logic            retire;
  logic            cond;
  logic            legal;
  logic [XLEN-1:0] target_c;

  // Compare and target evaluation on the incoming request.
  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (bus.in_type)
      3'b000:  cond = (bus.in_rs1 == bus.in_rs2);
      3'b001:  cond = (bus.in_rs1 != bus.in_rs2);
      3'b100:  cond = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
      3'b101:  cond = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
      3'b110:  cond = (bus.in_rs1 <  bus.in_rs2);
      3'b111:  cond = (bus.in_rs1 >= bus.in_rs2);
      default: legal = 1'b0;  // 010 / 011: not a branch encoding
    endcase
    target_c = bus.in_pc + bus.in_imm;
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  // flush kills both the acceptance and the retirement of this cycle.
  assign accept = bus.in_valid && bus.in_ready && !flush;
  assign retire = valid_q && bus.out_ready && !flush;

  always_comb begin
    valid_d    = valid_q;
    taken_d    = taken_q;
    target_d   = target_q;
    mispred_d  = mispred_q;
    redirect_d = redirect_q;
    misal_d    = misal_q;
    illegal_d  = illegal_q;
    cnt_br_d   = cnt_br_q;
    cnt_mp_d   = cnt_mp_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      taken_d    = cond;
      target_d   = target_c;
      mispred_d  = legal && (cond != bus.in_pred_taken);
      redirect_d = cond ? target_c : bus.in_pc + XLEN'(ILEN_B);
      misal_d    = cond && (target_c[1:0] != 2'b00);
      illegal_d  = !legal;
    end else if (retire) begin
      valid_d = 1'b0;
    end

    if (cnt_clr) begin
      cnt_br_d = '0;
      cnt_mp_d = '0;
    end else if (retire) begin
      if (!illegal_q && cnt_br_q != {CNT_W{1'b1}}) cnt_br_d = cnt_br_q + 1'b1;
      if (mispred_q  && cnt_mp_q != {CNT_W{1'b1}}) cnt_mp_d = cnt_mp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      mispred_q  <= 1'b0;
      redirect_q <= '0;
      misal_q    <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_br_q   <= '0;
      cnt_mp_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      taken_q    <= taken_d;
      target_q   <= target_d;
      mispred_q  <= mispred_d;
      redirect_q <= redirect_d;
      misal_q    <= misal_d;
      illegal_q  <= illegal_d;
      cnt_br_q   <= cnt_br_d;
      cnt_mp_q   <= cnt_mp_d;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_taken      = taken_q;
  assign bus.out_target     = target_q;
  assign bus.out_mispredict = mispred_q;
  assign bus.out_redirect   = redirect_q;
  assign bus.out_misaligned = misal_q;
  assign bus.out_illegal    = illegal_q;
  assign cnt_branches       = cnt_br_q;
  assign cnt_mispred        = cnt_mp_q;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;
  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic cnt_clr = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] cb, cm;   // main counters (CNT_W=16)
  logic [1:0]  sb, sm;   // saturation instance counters (CNT_W=2)

  branch_unit_if #(.XLEN(XLEN)) bus ();
  branch_unit_if #(.XLEN(XLEN)) bus_s ();

  // The CNT_W=2 instance sees exactly the same traffic as the main one.
  assign bus_s.in_valid      = bus.in_valid;
  assign bus_s.in_type       = bus.in_type;
  assign bus_s.in_rs1        = bus.in_rs1;
  assign bus_s.in_rs2        = bus.in_rs2;
  assign bus_s.in_pc         = bus.in_pc;
  assign bus_s.in_imm        = bus.in_imm;
  assign bus_s.in_pred_taken = bus.in_pred_taken;
  assign bus_s.out_ready     = bus.out_ready;

  branch_unit #(.XLEN(XLEN), .CNT_W(16), .ILEN_B(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
    .cnt_branches(cb), .cnt_mispred(cm), .bus(bus)
  );

  branch_unit #(.XLEN(XLEN), .CNT_W(2), .ILEN_B(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
    .cnt_branches(sb), .cnt_mispred(sm), .bus(bus_s)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        taken, mispred, misal, illegal;
    logic [31:0] target, redirect;
  } res_t;

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pred;
    logic        e_taken, e_mispred, e_misal, e_illegal;
    logic [31:0] e_target, e_redirect;
  } vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  bit   m_valid = 0;
  res_t m_res;
  int   m_cb = 0, m_cm = 0;  // unbounded retire counts since last clear

  function automatic res_t ref_result(input logic [2:0] typ, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] pc,
                                      input logic [31:0] imm, input logic pred);
    res_t r;
    logic c;
    bit   ok;
    c  = 1'b0;
    ok = 1'b1;
    case (typ)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = ($signed(a) <  $signed(b));
      3'd5: c = ($signed(a) >= $signed(b));
      3'd6: c = (a <  b);
      3'd7: c = (a >= b);
      default: ok = 1'b0;
    endcase
    r.illegal  = !ok;
    r.taken    = c;
    r.target   = pc + imm;
    r.redirect = c ? r.target : pc + 32'd4;
    r.mispred  = ok && (c != pred);
    r.misal    = c && (r.target[1:0] != 2'b00);
    return r;
  endfunction

  function automatic int sat(input int c, input int maxv);
    return (c > maxv) ? maxv : c;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input bit v, input logic [2:0] typ, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] imm, input logic pred);
    bus.in_valid      = v;
    bus.in_type       = typ;
    bus.in_rs1        = a;
    bus.in_rs2        = b;
    bus.in_pc         = pc;
    bus.in_imm        = imm;
    bus.in_pred_taken = pred;
  endtask

  // Called at posedge+1 with inputs already driven: checks the DUT against
  // the model, advances the model by one edge, returns at the next posedge+1.
  task automatic cycle();
    bit rdy, acc, ret;
    #1;
    rdy = !m_valid || bus.out_ready;
    chk("in_ready",  bus.in_ready,  rdy);
    chk("out_valid", bus.out_valid, m_valid);
    if (m_valid) begin
      chk("out_target",   bus.out_target,   m_res.target);
      chk("out_redirect", bus.out_redirect, m_res.redirect);
      chk("out_flags", {bus.out_taken, bus.out_mispredict, bus.out_misaligned, bus.out_illegal},
          {m_res.taken, m_res.mispred, m_res.misal, m_res.illegal});
    end
    chk("cnt_branches", cb, sat(m_cb, 65535));
    chk("cnt_mispred",  cm, sat(m_cm, 65535));
    chk("sat_branches", sb, sat(m_cb, 3));
    chk("sat_mispred",  sm, sat(m_cm, 3));
    acc = bus.in_valid && rdy && !flush;
    ret = m_valid && bus.out_ready && !flush;
    if (ret) begin
      if (!m_res.illegal) m_cb++;
      if (m_res.mispred)  m_cm++;
    end
    if (cnt_clr) begin
      m_cb = 0;
      m_cm = 0;
    end
    if (flush)    m_valid = 0;
    else if (acc) begin
      m_valid = 1;
      m_res   = ref_result(bus.in_type, bus.in_rs1, bus.in_rs2, bus.in_pc, bus.in_imm,
                           bus.in_pred_taken);
    end else if (ret) m_valid = 0;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];

  initial begin
    // ----- reset -----
    set_in(0, 3'd0, '0, '0, '0, '0, 1'b0);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_flags", {bus.out_taken, bus.out_mispredict, bus.out_misaligned, bus.out_illegal}, 0);
    chk("rst_target",   bus.out_target, 0);
    chk("rst_redirect", bus.out_redirect, 0);
    chk("rst_cnt", {cb, cm, sb, sm}, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1'b1;

    // ----- table-driven vectors -----
    //         typ   rs1           rs2           pc            imm           pr tk mp ma il target        redirect
    vecs[0]  = '{3'd5, 32'd5,        32'd5,        32'h1000,     32'h40,       0, 1, 1, 0, 0, 32'h1040,     32'h1040};
    vecs[1]  = '{3'd4, 32'hFFFFFFFF, 32'd1,        32'h2000,     32'h10,       1, 1, 0, 0, 0, 32'h2010,     32'h2010};
    vecs[2]  = '{3'd6, 32'hFFFFFFFF, 32'd1,        32'h2000,     32'h10,       1, 0, 1, 0, 0, 32'h2010,     32'h2004};
    vecs[3]  = '{3'd0, 32'd7,        32'd7,        32'hFFFFFFF0, 32'h20,       1, 1, 0, 0, 0, 32'h10,       32'h10};
    vecs[4]  = '{3'd0, 32'd7,        32'd7,        32'hFFFFFFF0, 32'h22,       1, 1, 0, 1, 0, 32'h12,       32'h12};
    vecs[5]  = '{3'd1, 32'd3,        32'd3,        32'h100,      32'hFFFFFFF8, 1, 0, 1, 0, 0, 32'hF8,       32'h104};
    vecs[6]  = '{3'd3, 32'd1,        32'd1,        32'h300,      32'h8,        1, 0, 0, 0, 1, 32'h308,      32'h304};
    vecs[7]  = '{3'd7, 32'd0,        32'hFFFFFFFF, 32'h400,      32'h100,      0, 0, 0, 0, 0, 32'h500,      32'h404};
    vecs[8]  = '{3'd5, 32'h80000000, 32'd0,        32'h500,      32'h4,        0, 0, 0, 0, 0, 32'h504,      32'h504};
    vecs[9]  = '{3'd2, 32'd9,        32'd9,        32'h600,      32'h10,       0, 0, 0, 0, 1, 32'h610,      32'h604};
    vecs[10] = '{3'd4, 32'h7FFFFFFF, 32'h80000000, 32'h700,      32'h20,       1, 0, 1, 0, 0, 32'h720,      32'h704};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_in(1, vecs[i].typ, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].imm, vecs[i].pred);
      cycle();
      chk("tbl_target",   bus.out_target,   vecs[i].e_target);
      chk("tbl_redirect", bus.out_redirect, vecs[i].e_redirect);
      chk("tbl_flags", {bus.out_taken, bus.out_mispredict, bus.out_misaligned, bus.out_illegal},
          {vecs[i].e_taken, vecs[i].e_mispred, vecs[i].e_misal, vecs[i].e_illegal});
    end
    set_in(0, 3'd0, '0, '0, '0, '0, 1'b0);
    cycle();
    chk("tbl_cnt_br", cb, 9);
    chk("tbl_cnt_mp", cm, 4);
    chk("tbl_sat_br", sb, 3);
    chk("tbl_sat_mp", sm, 3);

    // ----- stall: result held 3 cycles, then one retire -----
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1, 3'd5, 32'd5, 32'd5, 32'h1000, 32'h40, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 3'd0, 32'd1, 32'd2, 32'h9000 + 32'(i * 16), 32'h8, 1'b1);
      chk("stall_in_ready", bus.in_ready, 0);
      cycle();
      chk("stall_target",   bus.out_target, 32'h1040);
      chk("stall_mispred",  bus.out_mispredict, 1);
    end
    set_in(0, 3'd0, '0, '0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    cycle();
    chk("stall_valid_after", bus.out_valid, 0);
    chk("stall_cnt_br", cb, 1);
    chk("stall_cnt_mp", cm, 1);

    // ----- back-to-back 8 accepts -----
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_in(1, 3'd0, 32'(i), 32'(i), 32'h4000 + 32'(i * 4), 32'h100, 1'b1);
      cycle();
      chk("b2b_valid", bus.out_valid, 1);
    end
    set_in(0, 3'd0, '0, '0, '0, '0, 1'b0);
    cycle();
    chk("b2b_cnt_br", cb, 8);
    chk("b2b_sat_br", sb, 3);

    // ----- flush kills held result and same-cycle accept -----
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1, 3'd1, 32'd1, 32'd2, 32'h800, 32'h40, 1'b0);
    cycle();
    flush = 1'b1;
    bus.out_ready = 1'b1;
    set_in(1, 3'd0, 32'd1, 32'd1, 32'h900, 32'h40, 1'b0);
    cycle();
    flush = 1'b0;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_cnt",   {cb, cm}, 0);
    // illegal type retires without counting
    set_in(1, 3'd3, 32'd1, 32'd1, 32'hA00, 32'h40, 1'b0);
    cycle();
    chk("illegal_flag", bus.out_illegal, 1);
    chk("illegal_mp",   bus.out_mispredict, 0);
    set_in(0, 3'd0, '0, '0, '0, '0, 1'b0);
    cycle();
    chk("illegal_cnt", {cb, cm}, 0);

    // ----- randomized traffic against the model -----
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      set_in($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a,
             ($urandom_range(0, 2) == 0) ? a : $urandom, $urandom,
             ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom,
             1'($urandom_range(0, 1)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      cnt_clr       = ($urandom_range(0, 79) == 0);
      cycle();
    end
    flush   = 1'b0;
    cnt_clr = 1'b0;

    // ----- reset mid-operation -----
    bus.out_ready = 1'b0;
    set_in(1, 3'd0, 32'd4, 32'd4, 32'hB00, 32'h10, 1'b0);
    cycle();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_cnt", {cb, cm, sb, sm}, 0);
    m_valid = 0;
    m_cb    = 0;
    m_cm    = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_in(0, 3'd0, '0, '0, '0, '0, 1'b0);
    cycle();
    chk("midrst_in_ready", bus.in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
